// File: rtl/key_menu_pkg.sv
// rtl/key_menu_pkg.sv - menu state and key-priority encoding shared with the display driver
package key_menu_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SEL  = 2'd1,
    ST_EDIT = 2'd2
  } menu_st_t;

  typedef enum logic [2:0] {
    KEY_NONE = 3'd0,
    KEY_MODE = 3'd1,
    KEY_OK   = 3'd2,
    KEY_UP   = 3'd3,
    KEY_DOWN = 3'd4
  } key_t;

  // One action per cycle: mode beats ok beats up beats down.
  function automatic key_t key_prio(input logic mode, input logic ok,
                                    input logic up, input logic down);
    if (mode)      return KEY_MODE;
    else if (ok)   return KEY_OK;
    else if (up)   return KEY_UP;
    else if (down) return KEY_DOWN;
    else           return KEY_NONE;
  endfunction

endpackage

// File: rtl/menu_timeout_timer.sv
// rtl/menu_timeout_timer.sv - idle counter that pulses expire after TIMEOUT quiet cycles
module menu_timeout_timer #(
  parameter int TIMEOUT = 50_000_000
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic run,
  output logic expire
);

  localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CW-1:0] LAST = CW'(TIMEOUT - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  // A clear on the expiry cycle suppresses expire so the key action wins.
  always_comb begin
    expire = run && !clear && (cnt_q == LAST);
    if (clear || !run || expire) cnt_d = '0;
    else                         cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

endmodule

// File: rtl/key_menu_fsm.sv
// rtl/key_menu_fsm.sv - front-panel parameter menu: select, edit shadow, commit or discard
module key_menu_fsm
  import key_menu_pkg::*;
#(
  parameter int NPARAM  = 4,
  parameter int W       = 12,
  parameter int STEP    = 1,
  parameter int PMAX    = 4095,
  parameter int PDEF    = 0,
  parameter int TIMEOUT = 50_000_000,
  localparam int IW     = (NPARAM > 1) ? $clog2(NPARAM) : 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              k_mode,
  input  logic              k_ok,
  input  logic              k_up,
  input  logic              k_down,
  output logic [NPARAM*W-1:0] param_flat,
  output logic [1:0]        state,
  output logic [IW-1:0]     sel_idx,
  output logic [W-1:0]      edit_val,
  output logic              upd,
  output logic [IW-1:0]     upd_idx,
  output logic              tmo
);

  localparam logic [IW-1:0] IDX_LAST = IW'(NPARAM - 1);
  localparam logic [W-1:0]  PMAX_W   = W'(PMAX);
  localparam logic [W-1:0]  STEP_W   = W'(STEP);

  menu_st_t      state_q, state_d;
  logic [IW-1:0] sel_q, sel_d;
  logic [W-1:0]  edit_q, edit_d;
  logic          upd_q, upd_d;
  logic [IW-1:0] upd_idx_q, upd_idx_d;
  logic          tmo_q, tmo_d;
  logic [W-1:0]  param_q [NPARAM];
  logic [W-1:0]  param_d [NPARAM];

  key_t key;
  logic any_key;
  logic expire;

  assign key     = key_prio(k_mode, k_ok, k_up, k_down);
  assign any_key = k_mode | k_ok | k_up | k_down;

  menu_timeout_timer #(.TIMEOUT(TIMEOUT)) u_timer (
    .clk    (clk),
    .rst    (rst),
    .clear  (any_key),
    .run    (state_q != ST_IDLE),
    .expire (expire)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      sel_q     <= '0;
      edit_q    <= '0;
      upd_q     <= 1'b0;
      upd_idx_q <= '0;
      tmo_q     <= 1'b0;
      param_q   <= '{default: W'(PDEF)};
    end else begin
      state_q   <= state_d;
      sel_q     <= sel_d;
      edit_q    <= edit_d;
      upd_q     <= upd_d;
      upd_idx_q <= upd_idx_d;
      tmo_q     <= tmo_d;
      param_q   <= param_d;
    end
  end

  always_comb begin
    state_d = state_q;
    if (expire) begin
      state_d = ST_IDLE;
    end else begin
      case (key)
        KEY_MODE: state_d = (state_q == ST_SEL) ? ST_IDLE : ST_SEL;
        KEY_OK: begin
          if (state_q == ST_SEL)       state_d = ST_EDIT;
          else if (state_q == ST_EDIT) state_d = ST_SEL;
        end
        default: state_d = state_q;
      endcase
    end
  end

  always_comb begin
    sel_d     = sel_q;
    edit_d    = edit_q;
    upd_d     = 1'b0;
    upd_idx_d = upd_idx_q;
    tmo_d     = expire;
    param_d   = param_q;
    if (state_q == ST_SEL) begin
      case (key)
        KEY_UP:   sel_d = (sel_q == IDX_LAST) ? '0 : sel_q + 1'b1;
        KEY_DOWN: sel_d = (sel_q == '0) ? IDX_LAST : sel_q - 1'b1;
        KEY_OK:   edit_d = param_q[sel_q];
        default:  ;
      endcase
    end else if (state_q == ST_EDIT) begin
      // Compare before adding so the shadow never wraps past PMAX or below zero.
      case (key)
        KEY_UP:   edit_d = (edit_q > PMAX_W - STEP_W) ? PMAX_W : edit_q + STEP_W;
        KEY_DOWN: edit_d = (edit_q < STEP_W) ? '0 : edit_q - STEP_W;
        KEY_OK: begin
          param_d[sel_q] = edit_q;
          upd_d          = 1'b1;
          upd_idx_d      = sel_q;
        end
        default: ;
      endcase
    end
  end

  assign state    = state_q;
  assign sel_idx  = sel_q;
  assign edit_val = edit_q;
  assign upd      = upd_q;
  assign upd_idx  = upd_idx_q;
  assign tmo      = tmo_q;

  genvar gi;
  generate
    for (gi = 0; gi < NPARAM; gi++) begin : g_flat
      assign param_flat[gi*W +: W] = param_q[gi];
    end
  endgenerate

endmodule
